// File: rtl/vending_machine_change.sv
// Coin-width classifier and credit accumulator with nickel-pulse refund.
// Coins are measured on a two-stage synchronised sensor; refunds run as a Moore FSM.
module vending_machine_change #(
  parameter int dimeMin            = 2,
  parameter int dimeMax            = 4,
  parameter int nickelMin          = 6,
  parameter int nickelMax          = 8,
  parameter int quarterMin         = 10,
  parameter int quarterMax         = 12,
  parameter int PRICE_NICKELS      = 5,
  parameter int MAX_CREDIT_NICKELS = 20,
  parameter int CREDIT_W           = 5,
  parameter int CNT_W              = 21
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                coinSensor,
  input  logic                returnReq,
  output logic                dispense,
  output logic                coinReject,
  output logic                changeNickel,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy
);

  if (PRICE_NICKELS < 5 || PRICE_NICKELS > MAX_CREDIT_NICKELS) begin : g_bad_price
    $error("PRICE_NICKELS out of range");
  end
  if ((2 ** CREDIT_W) <= MAX_CREDIT_NICKELS) begin : g_bad_credit_w
    $error("CREDIT_W too narrow for MAX_CREDIT_NICKELS");
  end

  typedef enum logic [1:0] {IDLE, RET_HI, RET_LO} state_t;
  typedef logic [CREDIT_W:0] sum_t;

  localparam logic [CNT_W-1:0] D_MIN = CNT_W'(dimeMin);
  localparam logic [CNT_W-1:0] D_MAX = CNT_W'(dimeMax);
  localparam logic [CNT_W-1:0] N_MIN = CNT_W'(nickelMin);
  localparam logic [CNT_W-1:0] N_MAX = CNT_W'(nickelMax);
  localparam logic [CNT_W-1:0] Q_MIN = CNT_W'(quarterMin);
  localparam logic [CNT_W-1:0] Q_MAX = CNT_W'(quarterMax);
  localparam sum_t PRICE = sum_t'(PRICE_NICKELS);
  localparam sum_t MAXC  = sum_t'(MAX_CREDIT_NICKELS);

  state_t              state_q, state_d;
  logic                cs_q, cs_qq;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                flag_q, flag_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic                disp_q, disp_d;
  logic                rej_q, rej_d;

  logic       evt;
  logic       sat;
  logic       valid;
  logic [2:0] val;
  sum_t       sum;

  assign evt = !cs_q && cs_qq;
  assign sat = &cnt_q;

  always_comb begin
    val   = 3'd0;
    valid = 1'b0;
    unique case (1'b1)
      (cnt_q >= D_MIN && cnt_q <= D_MAX): begin val = 3'd2; valid = 1'b1; end
      (cnt_q >= N_MIN && cnt_q <= N_MAX): begin val = 3'd1; valid = 1'b1; end
      (cnt_q >= Q_MIN && cnt_q <= Q_MAX): begin val = 3'd5; valid = 1'b1; end
      default: ;
    endcase
    if (sat) valid = 1'b0;
  end

  assign sum = {1'b0, credit_q} + sum_t'(val);

  // Pulse-start flag marks coins that began while a refund was running.
  always_comb begin
    cnt_d  = cnt_q;
    flag_d = flag_q;
    if (evt) cnt_d = '0;
    else if (cs_q && !sat) cnt_d = cnt_q + 1'b1;
    if (cs_q && cnt_q == '0) flag_d = (state_q != IDLE);
  end

  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    disp_d   = disp_q;
    rej_d    = rej_q;
    if (evt) begin
      if (state_q == IDLE && !flag_q && valid && sum <= MAXC) begin
        rej_d = 1'b0;
        if (sum >= PRICE) begin
          disp_d   = 1'b1;
          credit_d = CREDIT_W'(sum - PRICE);
        end else begin
          disp_d   = 1'b0;
          credit_d = CREDIT_W'(sum);
        end
      end else begin
        rej_d  = 1'b1;
        disp_d = 1'b0;
      end
    end
    unique case (state_q)
      IDLE: begin
        if (returnReq && credit_q != '0 && !cs_q && cnt_q == '0)
          state_d = RET_HI;
      end
      RET_HI: begin
        credit_d = credit_q - 1'b1;
        state_d  = RET_LO;
      end
      RET_LO: begin
        state_d = (credit_q == '0) ? IDLE : RET_HI;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cs_q     <= 1'b0;
      cs_qq    <= 1'b0;
      cnt_q    <= '0;
      flag_q   <= 1'b0;
      credit_q <= '0;
      disp_q   <= 1'b0;
      rej_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cs_q     <= coinSensor;
      cs_qq    <= cs_q;
      cnt_q    <= cnt_d;
      flag_q   <= flag_d;
      credit_q <= credit_d;
      disp_q   <= disp_d;
      rej_q    <= rej_d;
    end
  end

  assign dispense     = disp_q;
  assign coinReject   = rej_q;
  assign credit       = credit_q;
  assign changeNickel = (state_q == RET_HI);
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_vending_machine_change.sv
// Bench for vending_machine_change: three price/ceiling variants,
// coin results via an expected-value queue, refund trains cycle by cycle.
module tb_vending_machine_change;

  logic       clk = 1'b0;
  logic       rst  [3];
  logic       cs   [3];
  logic       rr   [3];
  logic       disp [3];
  logic       rej  [3];
  logic       chg  [3];
  logic       bsy  [3];
  logic [4:0] cred [3];

  int n_vec = 0;
  int n_err = 0;
  int npulse [3] = '{0, 0, 0};
  int mc [3] = '{0, 0, 0};
  int pr [3] = '{5, 20, 16};
  int mx [3] = '{20, 20, 16};

  typedef struct {
    int   u;
    logic d;
    logic r;
    int   c;
  } exp_t;
  exp_t sb [$];

  always #5 clk = ~clk;

  vending_machine_change u0 (
    .clk(clk), .reset(rst[0]), .coinSensor(cs[0]), .returnReq(rr[0]),
    .dispense(disp[0]), .coinReject(rej[0]), .changeNickel(chg[0]),
    .credit(cred[0]), .busy(bsy[0]));

  vending_machine_change #(.PRICE_NICKELS(20)) u1 (
    .clk(clk), .reset(rst[1]), .coinSensor(cs[1]), .returnReq(rr[1]),
    .dispense(disp[1]), .coinReject(rej[1]), .changeNickel(chg[1]),
    .credit(cred[1]), .busy(bsy[1]));

  vending_machine_change #(.PRICE_NICKELS(16), .MAX_CREDIT_NICKELS(16)) u2 (
    .clk(clk), .reset(rst[2]), .coinSensor(cs[2]), .returnReq(rr[2]),
    .dispense(disp[2]), .coinReject(rej[2]), .changeNickel(chg[2]),
    .credit(cred[2]), .busy(bsy[2]));

  always @(negedge clk)
    for (int u = 0; u < 3; u++)
      if (chg[u] === 1'b1) npulse[u]++;

  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int coin_val(input int w);
    if (w >= 2 && w <= 4) return 2;
    if (w >= 6 && w <= 8) return 1;
    if (w >= 10 && w <= 12) return 5;
    return 0;
  endfunction

  task automatic do_reset(input int u);
    @(negedge clk) rst[u] = 1'b1;
    @(negedge clk) rst[u] = 1'b0;
    mc[u] = 0;
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 1, 0);
      return;
    end
    e = sb.pop_front();
    check({tag, "_disp"}, int'(disp[e.u]), int'(e.d));
    check({tag, "_rej"}, int'(rej[e.u]), int'(e.r));
    check({tag, "_cred"}, int'(cred[e.u]), e.c);
  endtask

  task automatic coin(input int u, input int w, input string tag);
    exp_t e;
    int   v;
    int   s;
    v = coin_val(w);
    s = mc[u] + v;
    e.u = u; e.d = 1'b0; e.r = 1'b1; e.c = mc[u];
    if (v != 0 && s <= mx[u]) begin
      e.r = 1'b0;
      if (s >= pr[u]) begin
        e.d = 1'b1;
        s   = s - pr[u];
      end
      mc[u] = s;
      e.c   = s;
    end
    sb.push_back(e);
    @(negedge clk) cs[u] = 1'b1;
    repeat (w) @(negedge clk);
    cs[u] = 1'b0;
    repeat (4) @(negedge clk);
    pop_check(tag);
  endtask

  task automatic load3();
    do_reset(0);
    coin(0, 3, "pre_d");
    coin(0, 7, "pre_n");
  endtask

  initial begin
    logic [11:0] chgv;
    logic [11:0] bsyv;
    int          p0;
    exp_t        e;

    for (int u = 0; u < 3; u++) begin
      rst[u] = 1'b1; cs[u] = 1'b0; rr[u] = 1'b0;
    end
    repeat (2) @(negedge clk);
    for (int u = 0; u < 3; u++) rst[u] = 1'b0;
    @(negedge clk);
    for (int u = 0; u < 3; u++)
      check($sformatf("reset_u%0d", u),
            int'({disp[u], rej[u], chg[u], bsy[u], cred[u]}), 0);

    for (int i = 0; i < 7; i++) coin(0, 3, $sformatf("dime%0d", i));

    do_reset(0);
    for (int i = 0; i < 5; i++) begin
      coin(0, 11, $sformatf("qn_q%0d", i));
      coin(0, 7, $sformatf("qn_n%0d", i));
    end
    coin(0, 3, "qn_d0");
    coin(0, 3, "qn_d1");

    do_reset(0);
    coin(0, 1, "bad_w1");
    coin(0, 5, "bad_w5");
    coin(0, 9, "bad_w9");
    coin(0, 13, "bad_w13");

    do_reset(1);
    for (int i = 0; i < 4; i++) coin(1, 11, $sformatf("p20_q%0d", i));

    do_reset(2);
    for (int i = 0; i < 4; i++) coin(2, 11, $sformatf("m16_q%0d", i));

    load3();
    @(negedge clk) rr[0] = 1'b1;
    chgv = '0;
    bsyv = '0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chgv[k] = chg[0];
      bsyv[k] = bsy[0];
    end
    rr[0] = 1'b0;
    mc[0] = 0;
    check("ret_chg_train", int'(chgv), int'(12'b0000_0001_0101));
    check("ret_busy_train", int'(bsyv), int'(12'b0000_0011_1111));
    check("ret_cred", int'(cred[0]), 0);

    load3();
    @(negedge clk) rr[0] = 1'b1;
    p0 = npulse[0];
    @(negedge clk) cs[0] = 1'b1;
    e.u = 0; e.d = 1'b0; e.r = 1'b1; e.c = 0;
    sb.push_back(e);
    repeat (11) @(negedge clk);
    cs[0] = 1'b0;
    repeat (4) @(negedge clk);
    rr[0] = 1'b0;
    mc[0] = 0;
    pop_check("ret_quarter");
    check("ret_quarter_pulses", npulse[0] - p0, 3);

    load3();
    @(negedge clk) rr[0] = 1'b1;
    p0 = npulse[0];
    @(negedge clk) rst[0] = 1'b1;
    @(negedge clk);
    check("rst_mid_outs",
          int'({disp[0], rej[0], chg[0], bsy[0], cred[0]}), 0);
    rst[0] = 1'b0;
    mc[0] = 0;
    repeat (10) @(negedge clk);
    check("rst_mid_pulses", npulse[0] - p0, 1);
    check("rst_mid_busy", int'(bsy[0]), 0);
    rr[0] = 1'b0;

    check("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
